// File: rtl/decode_queue.sv
// MIPS decode stage: decodes one instruction per cycle into an execute bundle held in a QDEPTH-entry queue.
// Latency: one cycle from acceptance to the queue head when empty; redirect is registered, one cycle after acceptance.
// Backpressure: in_ready drops when the queue is full, on a load-use hazard, or during flush; never looks at out_ready.
//
// Ports: clk/resetn (sync active-low); in_valid/in_ready/in_instr/in_pc + rs_val/rt_val from fetch/forwarding;
// ex_load_valid/ex_load_rd for load-use interlock; flush; out_* execute bundle at queue head with out_valid/out_ready;
// redirect_valid/redirect_pc back to fetch.
// Optional feature macro: DECODE_BRANCH_EXT_EN (BLTZ/BGEZ/BLEZ/BGTZ/JALR decode).
module decode_queue #(
    parameter int QDEPTH = 2,
    parameter int PC_W   = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic [PC_W-1:0] rs_val,
    input  logic [PC_W-1:0] rt_val,
    input  logic            ex_load_valid,
    input  logic [4:0]      ex_load_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_alu_op,
    output logic            out_alu_imm,
    output logic            out_alu_shamt,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_delay_slot,
    output logic            out_ri,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [PC_W-1:0] out_imm,
    output logic [PC_W-1:0] out_pc,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_NOR  = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_SRL  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;
    localparam logic [3:0] ALU_CMP  = 4'hE;
    localparam logic [3:0] ALU_PASS = 4'hF;

    typedef struct packed {
        logic [3:0]      alu_op;
        logic            alu_imm;
        logic            alu_shamt;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            delay_slot;
        logic            ri;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [PC_W-1:0] imm;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t              mem_q [QDEPTH];
    logic [QDEPTH-1:0]   ent_vld;
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic                ds_pending;

    // Decode outputs
    entry_t              d;
    logic                reads_rs;
    logic                reads_rt;
    logic                is_cti;
    logic                take;
    logic [PC_W-1:0]     tgt;
    logic                hazard;
    logic                full;
    logic                accept;
    logic                pop;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs_idx;
    logic [4:0]      rt_idx;
    logic [4:0]      rd_idx;
    logic [15:0]     imm16;
    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] imm_zext;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_plus8;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] j_target;
    logic            rs_neg;
    logic            rs_zero;

    assign opcode    = in_instr[31:26];
    assign funct     = in_instr[5:0];
    assign rs_idx    = in_instr[25:21];
    assign rt_idx    = in_instr[20:16];
    assign rd_idx    = in_instr[15:11];
    assign imm16     = in_instr[15:0];
    assign imm_sext  = {{(PC_W-16){imm16[15]}}, imm16};
    assign imm_zext  = {{(PC_W-16){1'b0}}, imm16};
    assign pc_plus4  = in_pc + PC_W'(4);
    assign pc_plus8  = in_pc + PC_W'(8);
    assign br_target = pc_plus4 + (imm_sext << 2);
    assign j_target  = {pc_plus4[PC_W-1:28], in_instr[25:0], 2'b00};
    assign rs_neg    = rs_val[PC_W-1];
    assign rs_zero   = (rs_val == '0);

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        d            = '0;
        d.alu_op     = ALU_ADD;
        d.rs         = rs_idx;
        d.rt         = rt_idx;
        d.rd         = rd_idx;
        d.shamt      = in_instr[10:6];
        d.imm        = imm_sext;
        d.pc         = in_pc;
        d.delay_slot = ds_pending;
        reads_rs     = 1'b0;
        reads_rt     = 1'b0;
        is_cti       = 1'b0;
        take         = 1'b0;
        tgt          = '0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
                        d.reg_write = 1'b1;
                        reads_rs    = 1'b1;
                        reads_rt    = 1'b1;
                        case (funct)
                            6'h23:   d.alu_op = ALU_SUB;
                            6'h24:   d.alu_op = ALU_AND;
                            6'h25:   d.alu_op = ALU_OR;
                            6'h26:   d.alu_op = ALU_XOR;
                            6'h27:   d.alu_op = ALU_NOR;
                            6'h2A:   d.alu_op = ALU_SLT;
                            6'h2B:   d.alu_op = ALU_SLTU;
                            default: d.alu_op = ALU_ADD;
                        endcase
                    end
                    6'h00, 6'h02, 6'h03: begin
                        d.reg_write = 1'b1;
                        d.alu_shamt = 1'b1;
                        reads_rt    = 1'b1;
                        d.alu_op    = (funct == 6'h00) ? ALU_SLL :
                                      (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                    end
                    6'h08: begin
                        reads_rs = 1'b1;
                        is_cti   = 1'b1;
                        take     = 1'b1;
                        tgt      = rs_val;
                    end
`ifdef DECODE_BRANCH_EXT_EN
                    6'h09: begin
                        reads_rs    = 1'b1;
                        is_cti      = 1'b1;
                        take        = 1'b1;
                        tgt         = rs_val;
                        d.imm       = pc_plus8;
                        d.alu_op    = ALU_PASS;
                        d.alu_imm   = 1'b1;
                        d.reg_write = 1'b1;
                    end
`endif
                    default: d.ri = 1'b1;
                endcase
            end
            6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
                d.alu_imm   = 1'b1;
                d.reg_write = 1'b1;
                d.rd        = rt_idx;
                reads_rs    = 1'b1;
                case (opcode)
                    6'h0A:   d.alu_op = ALU_SLT;
                    6'h0B:   d.alu_op = ALU_SLTU;
                    6'h0C:   d.alu_op = ALU_AND;
                    6'h0D:   d.alu_op = ALU_OR;
                    6'h0E:   d.alu_op = ALU_XOR;
                    default: d.alu_op = ALU_ADD;
                endcase
                // Logical immediates are zero-extended; arithmetic/compare ones keep the sign.
                if (opcode inside {6'h0C, 6'h0D, 6'h0E}) d.imm = imm_zext;
            end
            6'h0F: begin
                d.alu_imm   = 1'b1;
                d.reg_write = 1'b1;
                d.rd        = rt_idx;
                d.alu_op    = ALU_PASS;
                d.imm       = imm_zext << 16;
            end
            6'h23: begin
                d.alu_imm   = 1'b1;
                d.mem_read  = 1'b1;
                d.reg_write = 1'b1;
                d.rd        = rt_idx;
                reads_rs    = 1'b1;
            end
            6'h2B: begin
                d.alu_imm   = 1'b1;
                d.mem_write = 1'b1;
                d.rd        = rt_idx;
                reads_rs    = 1'b1;
                reads_rt    = 1'b1;
            end
            6'h04, 6'h05: begin
                d.alu_op = ALU_CMP;
                reads_rs = 1'b1;
                reads_rt = 1'b1;
                is_cti   = 1'b1;
                take     = (opcode == 6'h04) ? (rs_val == rt_val) : (rs_val != rt_val);
                tgt      = br_target;
            end
            6'h02: begin
                is_cti = 1'b1;
                take   = 1'b1;
                tgt    = j_target;
            end
            6'h03: begin
                is_cti      = 1'b1;
                take        = 1'b1;
                tgt         = j_target;
                d.rd        = 5'd31;
                d.imm       = pc_plus8;
                d.alu_op    = ALU_PASS;
                d.alu_imm   = 1'b1;
                d.reg_write = 1'b1;
            end
`ifdef DECODE_BRANCH_EXT_EN
            6'h01: begin
                if (rt_idx == 5'd0 || rt_idx == 5'd1) begin
                    d.alu_op = ALU_CMP;
                    reads_rs = 1'b1;
                    is_cti   = 1'b1;
                    take     = (rt_idx == 5'd0) ? rs_neg : !rs_neg;
                    tgt      = br_target;
                end else begin
                    d.ri = 1'b1;
                end
            end
            6'h06, 6'h07: begin
                d.alu_op = ALU_CMP;
                reads_rs = 1'b1;
                is_cti   = 1'b1;
                take     = (opcode == 6'h06) ? (rs_neg || rs_zero) : (!rs_neg && !rs_zero);
                tgt      = br_target;
            end
`endif
            default: d.ri = 1'b1;
        endcase
    end

    // Load-use interlock against the load in execute and any load still queued here.
    always_comb begin
        hazard = 1'b0;
        if (ex_load_valid) begin
            if (reads_rs && rs_idx != 5'd0 && rs_idx == ex_load_rd) hazard = 1'b1;
            if (reads_rt && rt_idx != 5'd0 && rt_idx == ex_load_rd) hazard = 1'b1;
        end
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_vld[i] && mem_q[i].mem_read) begin
                if (reads_rs && rs_idx != 5'd0 && rs_idx == mem_q[i].rd) hazard = 1'b1;
                if (reads_rt && rt_idx != 5'd0 && rt_idx == mem_q[i].rd) hazard = 1'b1;
            end
        end
    end

    assign full      = (count == CW'(QDEPTH));
    assign in_ready  = !full && !hazard && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_vld        <= '0;
            ds_pending     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
        end else if (flush) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            ent_vld        <= '0;
            ds_pending     <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            redirect_valid <= accept && take;
            if (accept && take) redirect_pc <= tgt;
            if (accept) begin
                mem_q[tail]   <= d;
                ent_vld[tail] <= 1'b1;
                tail          <= ptr_next(tail);
                ds_pending    <= is_cti;
            end
            // Push never targets the head slot while it is occupied, so these never collide.
            if (pop) begin
                ent_vld[head] <= 1'b0;
                head          <= ptr_next(head);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign out_alu_op     = mem_q[head].alu_op;
    assign out_alu_imm    = mem_q[head].alu_imm;
    assign out_alu_shamt  = mem_q[head].alu_shamt;
    assign out_reg_write  = mem_q[head].reg_write;
    assign out_mem_read   = mem_q[head].mem_read;
    assign out_mem_write  = mem_q[head].mem_write;
    assign out_delay_slot = mem_q[head].delay_slot;
    assign out_ri         = mem_q[head].ri;
    assign out_rs         = mem_q[head].rs;
    assign out_rt         = mem_q[head].rt;
    assign out_rd         = mem_q[head].rd;
    assign out_shamt      = mem_q[head].shamt;
    assign out_imm        = mem_q[head].imm;
    assign out_pc         = mem_q[head].pc;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue (QDEPTH=2, PC_W=32).
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Build with or without DECODE_BRANCH_EXT_EN to match the DUT.
module tb_decode_queue;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        ex_load_valid;
    logic [4:0]  ex_load_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_alu_op;
    logic        out_alu_imm, out_alu_shamt, out_reg_write, out_mem_read, out_mem_write;
    logic        out_delay_slot, out_ri;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [31:0] out_imm, out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] I_ADDIU = 32'h2422FFFF; // addiu r2,r1,-1
    localparam logic [31:0] I_BEQ   = 32'h10220004; // beq r1,r2,+4
    localparam logic [31:0] I_BNE   = 32'h14220004; // bne r1,r2,+4
    localparam logic [31:0] I_ADDU  = 32'h00221821; // addu r3,r1,r2
    localparam logic [31:0] I_ORI   = 32'h34248001; // ori r4,r1,0x8001
    localparam logic [31:0] I_JAL   = 32'h0C123456;
    localparam logic [31:0] I_J     = 32'h08000010;
    localparam logic [31:0] I_JR    = 32'h00200008; // jr r1
    localparam logic [31:0] I_LUI   = 32'h3C051234; // lui r5,0x1234
    localparam logic [31:0] I_BAD   = 32'hFC000000;
    localparam logic [31:0] I_LUSE  = 32'h00A41821; // addu r3,r5,r4
    localparam logic [31:0] I_LW    = 32'h8C260000; // lw r6,0(r1)
    localparam logic [31:0] I_USE6  = 32'h00C03821; // addu r7,r6,r0
    localparam logic [31:0] I_BGTZ  = 32'h1C200003; // bgtz r1,+3

    decode_queue #(.QDEPTH(2), .PC_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs_val(rs_val), .rt_val(rt_val),
        .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_alu_imm(out_alu_imm), .out_alu_shamt(out_alu_shamt),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_delay_slot(out_delay_slot), .out_ri(out_ri),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
    endtask

    task automatic drain_one();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; rs_val = '0; rt_val = '0;
        ex_load_valid = 1'b0; ex_load_rd = '0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %h want 0", out_valid); end
        n_cmp++; if (out_rd !== 5'd0) begin n_err++; $display("FAIL reset_out_rd got %h want 0", out_rd); end
        n_cmp++; if (out_imm !== 32'h0) begin n_err++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got %h want 0", out_pc); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL reset_redirect_valid got %h want 0", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h0) begin n_err++; $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_addiu();
        offer(I_ADDIU, 32'h40);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL addiu_in_ready got %h want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addiu_valid got %h want 1", out_valid); end
        n_cmp++; if (out_imm !== 32'hFFFFFFFF) begin n_err++; $display("FAIL addiu_imm got %h want ffffffff", out_imm); end
        n_cmp++; if (out_rd !== 5'd2) begin n_err++; $display("FAIL addiu_rd got %h want 2", out_rd); end
        n_cmp++; if (out_alu_op !== 4'h0) begin n_err++; $display("FAIL addiu_alu_op got %h want 0", out_alu_op); end
        n_cmp++; if (out_alu_imm !== 1'b1) begin n_err++; $display("FAIL addiu_alu_imm got %h want 1", out_alu_imm); end
        n_cmp++; if (out_reg_write !== 1'b1) begin n_err++; $display("FAIL addiu_reg_write got %h want 1", out_reg_write); end
        n_cmp++; if (out_delay_slot !== 1'b0) begin n_err++; $display("FAIL addiu_delay_slot got %h want 0", out_delay_slot); end
        n_cmp++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL addiu_pc got %h want 40", out_pc); end
        drain_one();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addiu_drained got %h want 0", out_valid); end
    endtask

    task automatic test_branch_taken();
        rs_val = 32'd7; rt_val = 32'd7;
        offer(I_BEQ, 32'h100);
        tick();
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL beq_redirect_valid got %h want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h114) begin n_err++; $display("FAIL beq_redirect_pc got %h want 114", redirect_pc); end
        n_cmp++; if (out_alu_op !== 4'hE) begin n_err++; $display("FAIL beq_alu_op got %h want e", out_alu_op); end
        n_cmp++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL beq_reg_write got %h want 0", out_reg_write); end
        offer(I_ADDU, 32'h104);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL beq_redirect_pulse got %h want 0", redirect_valid); end
        n_cmp++; if (out_pc !== 32'h104) begin n_err++; $display("FAIL slot_pc got %h want 104", out_pc); end
        n_cmp++; if (out_delay_slot !== 1'b1) begin n_err++; $display("FAIL slot_delay_slot got %h want 1", out_delay_slot); end
        n_cmp++; if (out_rd !== 5'd3) begin n_err++; $display("FAIL addu_rd got %h want 3", out_rd); end
        offer(I_ORI, 32'h108);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_delay_slot !== 1'b0) begin n_err++; $display("FAIL ori_delay_slot got %h want 0", out_delay_slot); end
        n_cmp++; if (out_imm !== 32'h00008001) begin n_err++; $display("FAIL ori_imm got %h want 8001", out_imm); end
        n_cmp++; if (out_alu_op !== 4'h3) begin n_err++; $display("FAIL ori_alu_op got %h want 3", out_alu_op); end
        n_cmp++; if (out_rd !== 5'd4) begin n_err++; $display("FAIL ori_rd got %h want 4", out_rd); end
        drain_one();
    endtask

    task automatic test_branch_not_taken();
        rs_val = 32'd5; rt_val = 32'd5;
        offer(I_BNE, 32'h200);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bne_redirect_valid got %h want 0", redirect_valid); end
        n_cmp++; if (out_alu_op !== 4'hE) begin n_err++; $display("FAIL bne_alu_op got %h want e", out_alu_op); end
        offer(I_ADDIU, 32'h204);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        n_cmp++; if (out_delay_slot !== 1'b1) begin n_err++; $display("FAIL bne_slot got %h want 1", out_delay_slot); end
        drain_one();
    endtask

    task automatic test_jumps();
        offer(I_JAL, 32'h10000100);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL jal_redirect_valid got %h want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h1048D158) begin n_err++; $display("FAIL jal_redirect_pc got %h want 1048d158", redirect_pc); end
        n_cmp++; if (out_rd !== 5'd31) begin n_err++; $display("FAIL jal_rd got %h want 1f", out_rd); end
        n_cmp++; if (out_imm !== 32'h10000108) begin n_err++; $display("FAIL jal_imm got %h want 10000108", out_imm); end
        n_cmp++; if (out_alu_op !== 4'hF) begin n_err++; $display("FAIL jal_alu_op got %h want f", out_alu_op); end
        drain_one();
        rs_val = 32'hDEADBEE0;
        offer(I_JR, 32'h800);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (redirect_pc !== 32'hDEADBEE0) begin n_err++; $display("FAIL jr_redirect_pc got %h want deadbee0", redirect_pc); end
        n_cmp++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL jr_reg_write got %h want 0", out_reg_write); end
        drain_one();
    endtask

    task automatic test_lui_ri();
        offer(I_LUI, 32'h300);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_imm !== 32'h12340000) begin n_err++; $display("FAIL lui_imm got %h want 12340000", out_imm); end
        n_cmp++; if (out_alu_op !== 4'hF) begin n_err++; $display("FAIL lui_alu_op got %h want f", out_alu_op); end
        n_cmp++; if (out_rd !== 5'd5) begin n_err++; $display("FAIL lui_rd got %h want 5", out_rd); end
        n_cmp++; if (out_delay_slot !== 1'b1) begin n_err++; $display("FAIL lui_after_jr_slot got %h want 1", out_delay_slot); end
        drain_one();
        offer(I_BAD, 32'h304);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ri_enqueued got %h want 1", out_valid); end
        n_cmp++; if (out_ri !== 1'b1) begin n_err++; $display("FAIL ri_flag got %h want 1", out_ri); end
        n_cmp++; if (out_reg_write !== 1'b0) begin n_err++; $display("FAIL ri_reg_write got %h want 0", out_reg_write); end
        drain_one();
    endtask

    task automatic test_load_use();
        ex_load_valid = 1'b1; ex_load_rd = 5'd5;
        offer(I_LUSE, 32'h400);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL loaduse_stall got %h want 0", in_ready); end
            tick();
        end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL loaduse_not_accepted got %h want 0", out_valid); end
        ex_load_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL loaduse_release got %h want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_pc !== 32'h400) begin n_err++; $display("FAIL loaduse_pc got %h want 400", out_pc); end
        drain_one();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL loaduse_once got %h want 0", out_valid); end
        // Load sitting in the queue blocks a dependent instruction too.
        offer(I_LW, 32'h500);
        tick();
        n_cmp++; if (out_mem_read !== 1'b1) begin n_err++; $display("FAIL lw_mem_read got %h want 1", out_mem_read); end
        n_cmp++; if (out_rd !== 5'd6) begin n_err++; $display("FAIL lw_rd got %h want 6", out_rd); end
        offer(I_USE6, 32'h504);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL queue_hazard got %h want 0", in_ready); end
        drain_one();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL queue_hazard_clear got %h want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_pc !== 32'h504) begin n_err++; $display("FAIL queue_hazard_pc got %h want 504", out_pc); end
        drain_one();
    endtask

    task automatic test_full();
        offer(I_ADDIU, 32'h600); tick();
        offer(I_ADDIU, 32'h604); tick();
        offer(I_ADDIU, 32'h608);
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready got %h want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_with_out_ready got %h want 0", in_ready); end
        tick();
        n_cmp++; if (out_pc !== 32'h604) begin n_err++; $display("FAIL drain_order_b got %h want 604", out_pc); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ready_returns got %h want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_pc !== 32'h608) begin n_err++; $display("FAIL drain_order_c got %h want 608", out_pc); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL c_valid got %h want 1", out_valid); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL full_drained got %h want 0", out_valid); end
    endtask

    task automatic test_flush();
        offer(I_ADDIU, 32'h700); tick();
        offer(I_J, 32'h704); tick();
        rs_val = 32'hDEADBEE0;
        offer(I_JR, 32'h708);
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %h want 0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %h want 0", out_valid); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL flush_redirect got %h want 0", redirect_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_jr_dropped got %h want 0", out_valid); end
        offer(I_ADDIU, 32'h70C);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (out_pc !== 32'h70C) begin n_err++; $display("FAIL post_flush_pc got %h want 70c", out_pc); end
        n_cmp++; if (out_delay_slot !== 1'b0) begin n_err++; $display("FAIL post_flush_slot got %h want 0", out_delay_slot); end
        drain_one();
    endtask

    task automatic test_bgtz();
        rs_val = 32'd1;
        offer(I_BGTZ, 32'h900);
        tick();
        in_valid = 1'b0;
`ifdef DECODE_BRANCH_EXT_EN
        n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL bgtz_redirect_valid got %h want 1", redirect_valid); end
        n_cmp++; if (redirect_pc !== 32'h910) begin n_err++; $display("FAIL bgtz_redirect_pc got %h want 910", redirect_pc); end
        n_cmp++; if (out_ri !== 1'b0) begin n_err++; $display("FAIL bgtz_ri got %h want 0", out_ri); end
        n_cmp++; if (out_alu_op !== 4'hE) begin n_err++; $display("FAIL bgtz_alu_op got %h want e", out_alu_op); end
`else
        n_cmp++; if (out_ri !== 1'b1) begin n_err++; $display("FAIL bgtz_ri got %h want 1", out_ri); end
        n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL bgtz_redirect_valid got %h want 0", redirect_valid); end
`endif
        drain_one();
    endtask

    task automatic test_reset_mid();
        offer(I_ADDIU, 32'hA00); tick();
        offer(I_ADDIU, 32'hA04);
        resetn = 1'b0;
        tick();
        resetn = 1'b1; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got %h want 0", out_valid); end
        n_cmp++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL midreset_pc got %h want 0", out_pc); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_no_push got %h want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_addiu();
        test_branch_taken();
        test_branch_not_taken();
        test_jumps();
        test_lui_ri();
        test_load_use();
        test_full();
        test_flush();
        test_bgtz();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered MIPS decode stage with a parametrised output queue, branch/jump resolution, load-use interlock and delay-slot tracking. It sits between fetch and execute in `mycpu`. It accepts one instruction per cycle over a valid/ready handshake and decodes it into an execute bundle. Taken branches and jumps are resolved here, and a registered redirect is sent back to fetch.

## Interface

Parameters:
- `QDEPTH`, default 2: output queue entries; power of two, 1..8.
- `PC_W`, default 32: width of PC and data paths.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  synchronous active-low reset.
- `in_valid` / `in_ready`  in/out  1  fetch handshake.
- `in_instr`, `in_pc`  in  32 / PC_W  instruction and its PC.
- `rs_val`, `rt_val`  in  PC_W  forwarded operand values, valid in the acceptance cycle.
- `ex_load_valid`  in  1  execute stage holds a load.
- `ex_load_rd`  in  5  that load's destination register.
- `flush`  in  1  discard all queued and in-flight state.
- `out_valid` / `out_ready`  out/in  1  execute handshake at the queue head.
- `out_alu_op`  out  4  ALU operation code.
- `out_alu_imm`, `out_alu_shamt`, `out_reg_write`, `out_mem_read`, `out_mem_write`, `out_delay_slot`, `out_ri`  out  1 each.
- `out_rs`, `out_rt`, `out_rd`, `out_shamt`  out  5 each.
- `out_imm`, `out_pc`  out  PC_W.
- `redirect_valid`  out  1  redirect request to fetch.
- `redirect_pc`  out  PC_W  redirect target.

## Operation

- Acceptance: an instruction is accepted when `in_valid && in_ready`.
  - `in_ready = !full && !hazard && !flush`.
  - `in_ready` never depends on `out_ready` in the same cycle.
- Hazard: asserted when the instruction reads `rs` or `rt` with a nonzero index and that index equals either:
  - `ex_load_rd` while `ex_load_valid` is high, or
  - the `out_rd` of any valid queue entry with `out_mem_read` set.
- ALU codes: ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SRA=7, SRL=8, SLT=9, SLTU=A, CMP=E, PASS_IMM=F.
- R-type instructions (`out_rd` = instr[15:11]):
  - ADDU, SUBU, AND, OR, NOR, XOR, SLT, SLTU.
  - SLL, SRA, SRL: `out_alu_shamt` = 1.
  - JR: `out_reg_write` = 0.
- I-type ALU instructions (`out_rd` = rt, `out_alu_imm` = 1):
  - Sign-extended immediate: ADDIU, SLTI, SLTIU.
  - Zero-extended immediate: ANDI, ORI, XORI.
  - LUI: `out_imm` = imm<<16, `out_alu_op` = PASS_IMM.
- Memory instructions: LW sets `out_mem_read` and writes rt; SW sets `out_mem_write` and writes no register.
- Branches: BEQ and BNE have `out_reg_write` = 0 and `out_alu_op` = CMP.
- Jumps:
  - J: no register write.
  - JAL: `out_rd` = 31, `out_imm` = `in_pc`+8, `out_alu_op` = PASS_IMM.
- Any other encoding: `out_ri` = 1 with every write/mem flag cleared. The entry is still enqueued.
- Redirect targets, latched on acceptance and presented the next cycle:
  - Taken branch: `pc+4+(sext(imm)<<2)`; BEQ is taken when `rs_val==rt_val`, BNE when they differ.
  - J / JAL: `{pc+4[31:28], instr[25:0], 2'b00}`.
  - JR: `rs_val`.
  - A branch that is not taken generates no redirect.
- Delay slot: after accepting any branch or jump, the next accepted instruction carries `out_delay_slot` = 1, whether or not the branch was taken.
- Queue: circular buffer of `QDEPTH` entries with head and tail pointers that wrap modulo `QDEPTH` and an occupancy counter running 0..QDEPTH.
  - Push and pop may happen in the same cycle; occupancy is then unchanged.
- Flush: takes priority over everything else.
  - Occupancy goes to 0 and the pending delay-slot flag is cleared.
  - Any redirect computed in that cycle is dropped.
  - An instruction presented in the flush cycle is not accepted.

## Timing

- Reset (`resetn` low at a clock edge):
  - All `out_*` signals are 0, `redirect_valid` is 0, `redirect_pc` is 0.
  - Occupancy and both pointers are 0; the delay-slot flag is 0.
  - Reset wins over flush and over a push.
  - Reset asserted mid-operation discards all queued entries.
- Latency: an instruction accepted at edge N appears at the queue head (`out_valid` = 1) after edge N when the queue was empty; otherwise it waits behind older entries.
- `redirect_valid` is a one-cycle pulse starting after the acceptance edge. Fetch must tolerate a redirect arriving while the delay-slot instruction is in flight.
- Full (occupancy == QDEPTH): `in_ready` = 0 even if `out_ready` = 1 in the same cycle.
- Empty: `out_valid` = 0. Head data holds its last value and must not be relied upon.
- Head output is stable while `out_valid && !out_ready`.

## Configuration

- `DECODE_BRANCH_EXT_EN` defined: the following are also decoded.
  - REGIMM BLTZ (rt=0) and BGEZ (rt=1), BLEZ and BGTZ: taken on a signed compare of `rs_val` against 0; `out_alu_op` = CMP.
  - JALR: target = `rs_val`, `out_rd` = instr[15:11], `out_imm` = pc+8.
- `DECODE_BRANCH_EXT_EN` undefined: all five of these encodings produce `out_ri` = 1 and never redirect.

## Test plan

- ADDIU r2,r1,-1 (0x2422FFFF), queue empty:
  - `out_valid` = 1 one cycle later.
  - `out_imm` = 0xFFFFFFFF, `out_rd` = 2, `out_alu_op` = 0, `out_alu_imm` = 1.
- BEQ at pc 0x100 with imm 4 and `rs_val == rt_val`:
  - Next cycle `redirect_valid` = 1 for exactly one cycle, `redirect_pc` = 0x114.
  - The following accepted instruction has `out_delay_slot` = 1.
- Load-use with `ex_load_valid` = 1 and `ex_load_rd` = 5, instruction ADDU r3,r5,r4:
  - `in_ready` = 0 until `ex_load_valid` drops.
  - Then the instruction is accepted once.
- QDEPTH=2 with `out_ready` held 0 and three instructions offered:
  - Two are accepted; `in_ready` = 0 at full.
  - With `out_ready` = 1, the entries drain in order and `in_ready` returns.
- `flush` asserted with 2 queued entries and a JR presented:
  - Next cycle `out_valid` = 0 and `redirect_valid` = 0; the JR is not accepted.
- BGTZ (0x1C200003) with `rs_val` = 1:
  - With `DECODE_BRANCH_EXT_EN`: redirect to pc+16.
  - Without it: `out_ri` = 1 and no redirect.
